// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arb_pkg
// Purpose  : Shared state encoding and sizing helpers for the DDR write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                                input int unsigned data_width);
        return burst_len * (data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_onehot
// Purpose  : Combinational round-robin pick: first request at or after i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_onehot #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grant_idx,
    output logic              o_any
);

    logic [CH_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((i_ptr + k) % NUM_CH);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_write_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_write_burst_arbiter
// Purpose  : Round-robin sequencing of per-line write bursts from NUM_CH video
//            channels onto one AXI4 write master; tracks per-channel frame
//            offsets. Optional DDR_ARB_WATCHDOG_EN adds a WAIT timeout (wdt_err).
// Revision : 1.0 - initial release
// ============================================================================
module ddr_write_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned AXI4_DATA_WIDTH = 128,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned FRAME_BYTES     = 32'h0054_6000,
    parameter int unsigned WDT_CYCLES      = 4096
) (
    input  logic                             M_AXI_ACLK,
    input  logic                             M_AXI_ARESET,
    input  logic [NUM_CH-1:0]                req_valid,
    output logic [NUM_CH-1:0]                req_ready,
    input  logic [NUM_CH-1:0]                frame_start,
    input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] ch_base_addr,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [AXI_ADDR_WIDTH-1:0]        cmd_addr,
    output logic [7:0]                       cmd_len,
    output logic [ch_w(NUM_CH)-1:0]          cmd_ch,
    input  logic                             burst_done,
`ifdef DDR_ARB_WATCHDOG_EN
    output logic                             wdt_err,
`endif
    output logic                             busy
);

    localparam int unsigned               c_ch_w        = ch_w(NUM_CH);
    localparam logic [AXI_ADDR_WIDTH:0]   c_burst_bytes =
        (AXI_ADDR_WIDTH+1)'(burst_bytes(BURST_LEN, AXI4_DATA_WIDTH));
    localparam logic [AXI_ADDR_WIDTH:0]   c_frame_bytes = (AXI_ADDR_WIDTH+1)'(FRAME_BYTES);

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic                      w_grant_fire;
    logic                      w_wdt_expire;
    logic                      w_gnt_any;
    logic [NUM_CH-1:0]         w_gnt_onehot;
    logic [c_ch_w-1:0]         w_gnt_idx;
    logic [c_ch_w-1:0]         w_rr_nxt;
    logic [c_ch_w-1:0]         r_rr_ptr;
    logic [c_ch_w-1:0]         r_cmd_ch;
    logic [NUM_CH-1:0]         r_req_ready;
    logic [AXI_ADDR_WIDTH-1:0] w_base [NUM_CH];
    logic [AXI_ADDR_WIDTH-1:0] r_off  [NUM_CH];
    logic [AXI_ADDR_WIDTH-1:0] w_eff_off;
    logic [AXI_ADDR_WIDTH-1:0] w_off_nxt;
    logic [AXI_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [AXI_ADDR_WIDTH:0]   w_off_sum;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_base
        assign w_base[gi] = ch_base_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    end

    rr_arbiter_onehot #(
        .NUM_CH (NUM_CH),
        .CH_W   (c_ch_w)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_gnt_onehot),
        .o_grant_idx (w_gnt_idx),
        .o_any       (w_gnt_any)
    );

    // A frame_start coinciding with the grant restarts that channel at offset 0.
    always_comb begin
        w_eff_off = frame_start[w_gnt_idx] ? '0 : r_off[w_gnt_idx];
        w_off_sum = {1'b0, w_eff_off} + c_burst_bytes;
        w_off_nxt = (w_off_sum >= c_frame_bytes) ? '0 : w_off_sum[AXI_ADDR_WIDTH-1:0];
        w_rr_nxt  = (w_gnt_idx == c_ch_w'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any) begin
                    w_state_nxt  = ST_CMD;
                    w_grant_fire = 1'b1;
                end
            end
            ST_CMD:  if (cmd_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: if (burst_done || w_wdt_expire) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_rr_ptr    <= '0;
            r_cmd_addr  <= '0;
            r_cmd_ch    <= '0;
            r_req_ready <= '0;
        end else begin
            r_req_ready <= w_grant_fire ? w_gnt_onehot : '0;
            if (w_grant_fire) begin
                r_rr_ptr   <= w_rr_nxt;
                r_cmd_addr <= w_base[w_gnt_idx] + w_eff_off;
                r_cmd_ch   <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (M_AXI_ARESET)                       r_off[i] <= '0;
            else if (w_grant_fire && w_gnt_onehot[i]) r_off[i] <= w_off_nxt;
            else if (frame_start[i])                r_off[i] <= '0;
        end
    end

`ifdef DDR_ARB_WATCHDOG_EN
    localparam logic [15:0] c_wdt_last = 16'(WDT_CYCLES - 1);

    logic [15:0] r_wdt_cnt;
    logic        r_wdt_err;

    assign w_wdt_expire = (r_state == ST_WAIT) && !burst_done && (r_wdt_cnt == c_wdt_last);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            r_wdt_err <= w_wdt_expire;
            if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) r_wdt_cnt <= r_wdt_cnt + 16'd1;
            else                                                 r_wdt_cnt <= '0;
        end
    end

    assign wdt_err = r_wdt_err;
`else
    logic w_unused_wdt_cfg;
    assign w_wdt_expire     = 1'b0;
    assign w_unused_wdt_cfg = (WDT_CYCLES == 0);
`endif

    assign req_ready = r_req_ready;
    assign cmd_valid = (r_state == ST_CMD);
    assign busy      = (r_state != ST_IDLE);
    assign cmd_addr  = r_cmd_addr;
    assign cmd_ch    = r_cmd_ch;
    assign cmd_len   = 8'(BURST_LEN - 1);

endmodule
`default_nettype wire
